// File: rtl/mac8_pkg.sv
// Shared types and widths for the mac8 multiply-accumulate slice.
package mac8_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mac8_ctrl.sv
// Frame controller: ACCUM -> FLUSH -> HOLD sequencing with registered in_ready/out_valid.
module mac8_ctrl
  import mac8_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_accept,
  input  logic i_last,
  input  logic i_last_added,
  input  logic i_consume,
  output logic o_in_ready,
  output logic o_out_valid
);

  state_e r_state;
  logic   r_in_ready;
  logic   r_out_valid;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_in_ready <= 1'b1;
          if (i_accept && i_last) begin
            r_state    <= FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          if (i_last_added) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (i_consume) begin
            r_state     <= ACCUM;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ACCUM;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;

endmodule

// File: rtl/multiplier_8bits_version15.sv
// Combinational 8x8 unsigned array multiplier: sum of shifted AND partial products.
module multiplier_8bits_version15
  import mac8_pkg::*;
(
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  output logic [PROD_W-1:0] o_prod
);

  logic [PROD_W-1:0] w_sum;

  always_comb begin
    // NOTE: default assignment first so this block can never infer a latch.
    w_sum = '0;
    for (int i = 0; i < OPND_W; i++) begin
      w_sum = w_sum + ({{(PROD_W-OPND_W){1'b0}}, i_a & {OPND_W{i_b[i]}}} << i);
    end
  end

  assign o_prod = w_sum;

endmodule

// File: rtl/mac8_accumulator.sv
// Pipelined 8x8 MAC summing one frame of products; define MAC8_SATURATE_EN to clamp
// the accumulator on carry-out instead of wrapping.
module mac8_accumulator
  import mac8_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  logic              w_accept;
  logic              w_consume;
  logic              w_last_added;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;

  logic [OPND_W-1:0] r_a_q;
  logic [OPND_W-1:0] r_b_q;
  logic              r_last_q;
  logic              r_v0;
  logic [PROD_W-1:0] r_prod_q;
  logic              r_last1;
  logic              r_v1;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  assign w_accept     = in_valid & in_ready;
  assign w_consume    = out_valid & out_ready;
  assign w_last_added = r_v1 & r_last1;
  assign w_sum        = {1'b0, r_acc} + {{(ACC_W+1-PROD_W){1'b0}}, r_prod_q};

  mac8_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_accept     (w_accept),
    .i_last       (in_last),
    .i_last_added (w_last_added),
    .i_consume    (w_consume),
    .o_in_ready   (in_ready),
    .o_out_valid  (out_valid)
  );

  multiplier_8bits_version15 u_mul (
    .i_a    (r_a_q),
    .i_b    (r_b_q),
    .o_prod (w_prod)
  );

  // Valid bits travel with the data so bubbles never reach the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q    <= '0;
      r_b_q    <= '0;
      r_last_q <= 1'b0;
      r_v0     <= 1'b0;
      r_prod_q <= '0;
      r_last1  <= 1'b0;
      r_v1     <= 1'b0;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) begin
        r_a_q    <= in_a;
        r_b_q    <= in_b;
        r_last_q <= in_last;
      end
      r_v1 <= r_v0;
      if (r_v0) begin
        r_prod_q <= w_prod;
        r_last1  <= r_last_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_consume) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (r_v1) begin
        r_ovf <= r_ovf | w_sum[ACC_W];
`ifdef MAC8_SATURATE_EN
        r_acc <= (r_ovf || w_sum[ACC_W]) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        r_acc <= w_sum[ACC_W-1:0];
`endif
      end
    end
  end

  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac8_accumulator.sv
// Drives three mac8_accumulator variants in lockstep and checks each against an exact-sum frame model.
module tb_mac8_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;

  logic        rdy_a, rdy_b, rdy_c;
  logic        ov_a, ov_b, ov_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [23:0] acc_a;
  logic [15:0] acc_b;
  logic [23:0] acc_c;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int     checks = 0;
  int     errors = 0;
  longint m_sum = 0;
  int     m_cnt = 0;

  always #5 clk = ~clk;

  mac8_accumulator #(.ACC_W(24), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_a),
    .out_ready(out_ready), .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  mac8_accumulator #(.ACC_W(16), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_b),
    .out_ready(out_ready), .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  mac8_accumulator #(.ACC_W(24), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(ov_c),
    .out_ready(out_ready), .out_acc(acc_c), .out_count(cnt_c), .out_ovf(ovf_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_acc(input longint s, input int w);
    longint lim;
    lim = longint'(64'd1 << w);
`ifdef MAC8_SATURATE_EN
    return (s >= lim) ? lim - 1 : s;
`else
    return s % lim;
`endif
  endfunction

  function automatic longint exp_ovf(input longint s, input int w);
    return (s >= longint'(64'd1 << w)) ? 64'd1 : 64'd0;
  endfunction

  task automatic check_out(input string tag);
    check({tag, " valid_a"}, 64'(ov_a), 64'd1);
    check({tag, " valid_b"}, 64'(ov_b), 64'd1);
    check({tag, " valid_c"}, 64'(ov_c), 64'd1);
    check({tag, " acc_a"}, 64'(acc_a), exp_acc(m_sum, 24));
    check({tag, " acc_b"}, 64'(acc_b), exp_acc(m_sum, 16));
    check({tag, " acc_c"}, 64'(acc_c), exp_acc(m_sum, 24));
    check({tag, " cnt_a"}, 64'(cnt_a), 64'(m_cnt % 256));
    check({tag, " cnt_b"}, 64'(cnt_b), 64'(m_cnt % 256));
    check({tag, " cnt_c"}, 64'(cnt_c), 64'(m_cnt % 4));
    check({tag, " ovf_a"}, 64'(ovf_a), exp_ovf(m_sum, 24));
    check({tag, " ovf_b"}, 64'(ovf_b), exp_ovf(m_sum, 16));
    check({tag, " ovf_c"}, 64'(ovf_c), exp_ovf(m_sum, 24));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (rdy_a !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 64'(rdy_a), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    m_sum += longint'(a) * longint'(b);
    m_cnt++;
    if (last) begin
      check("flush_rdy_a", 64'(rdy_a), 64'd0);
      check("flush_rdy_c", 64'(rdy_c), 64'd0);
    end
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (ov_a !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd2);
    check({tag, " hold_rdy"}, 64'(rdy_b), 64'd0);
    check_out(tag);
  endtask

  task automatic consume(input int stall);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      check_out("stall");
      check("stall_rdy", 64'(rdy_a), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid_a", 64'(ov_a), 64'd0);
    check("post_rdy_a", 64'(rdy_a), 64'd1);
    check("post_rdy_c", 64'(rdy_c), 64'd1);
    check("post_acc_a", 64'(acc_a), 64'd0);
    check("post_cnt_b", 64'(cnt_b), 64'd0);
    check("post_ovf_b", 64'(ovf_b), 64'd0);
    m_sum = 0;
    m_cnt = 0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rdy", 64'(rdy_a), 64'd0);
    check("rst_valid", 64'(ov_a), 64'd0);
    check("rst_acc", 64'(acc_a), 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_ovf", 64'(ovf_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", 64'(rdy_a), 64'd0);
    @(posedge clk); #1;
    check("rdy_after_edge", 64'(rdy_a), 64'd1);

    // Two-beat back-to-back frame: 15 + 65025
    send_beat(8'd3, 8'd5, 1'b0);
    send_beat(8'd255, 8'd255, 1'b1);
    wait_result("f2");
    check("f2_acc_const", 64'(acc_a), 64'd65040);
    consume(0);

    // Single-beat frame
    send_beat(8'd0, 8'd200, 1'b1);
    wait_result("single");
    consume(1);

    // 16-bit overflow: 2 x 65025
    send_beat(8'd255, 8'd255, 1'b0);
    send_beat(8'd255, 8'd255, 1'b1);
    wait_result("ovf16");
    consume(0);

    // Bubbles between beats, then a long stall in HOLD
    send_beat(8'd1, 8'd1, 1'b0); idle();
    send_beat(8'd1, 8'd1, 1'b0); idle();
    send_beat(8'd1, 8'd1, 1'b0); idle();
    send_beat(8'd1, 8'd1, 1'b1);
    wait_result("bubble");
    consume(5);

    // Asynchronous reset during FLUSH discards the frame
    send_beat(8'd10, 8'd10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cnt", 64'(cnt_a), 64'd0);
    check("midrst_rdy", 64'(rdy_a), 64'd0);
    check("midrst_valid", 64'(ov_a), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("midrst_no_out", 64'(ov_a), 64'd0);
    end
    send_beat(8'd2, 8'd3, 1'b1);
    wait_result("after_rst");
    consume(0);

    // 5-beat frame wraps the 2-bit counter
    for (int i = 0; i < 5; i++) send_beat(8'd1, 8'd2, 1'(i == 4));
    wait_result("cnt_wrap");
    consume(0);

    // Long frame carrying out of 24 bits and wrapping the 8-bit counter
    for (int i = 0; i < 260; i++) send_beat(8'd255, 8'd255, 1'(i == 259));
    wait_result("long");
    consume(2);

    // Randomized frames with random bubbles and stalls
    for (int f = 0; f < 8; f++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) idle();
        send_beat(8'($urandom), 8'($urandom), 1'(i == len - 1));
      end
      wait_result("rand");
      consume(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
